// File: rtl/sbox_ced_pkg.sv
// Shared types and helpers for the S-box concurrent-error-detection slice:
// injection encodings, GF(2^8) S-box math, quadratic signature and fault masks.
package sbox_ced_pkg;

  localparam int SIG_W = 4;

  typedef enum logic [1:0] {
    INJ_NONE = 2'd0,
    INJ_BYTE = 2'd1,
    INJ_BIT  = 2'd2,
    INJ_ALL  = 2'd3
  } inj_mode_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero for free.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Each bit is a linear parity plus one AND term, so complementing a byte
  // is only masked when every bit pair differs.
  function automatic logic [SIG_W-1:0] quad_sig(input logic [7:0] y);
    logic [SIG_W-1:0] s;
    s[0] = (^(y & 8'h55)) ^ (y[0] & y[1]);
    s[1] = (^(y & 8'h33)) ^ (y[2] & y[3]);
    s[2] = (^(y & 8'h0f)) ^ (y[4] & y[5]);
    s[3] = (^y)           ^ (y[6] & y[7]);
    return s;
  endfunction

  function automatic logic [7:0] fault_mask(input logic [1:0]  mode,
                                            input int unsigned lane,
                                            input logic [2:0]  bit_sel,
                                            input int unsigned idx);
    logic [7:0] m;
    m = 8'h00;
    case (inj_mode_e'(mode))
      INJ_BYTE: if (lane == idx) m = 8'hff;
      INJ_BIT:  if (lane == idx) m = 8'h01 << bit_sel;
      INJ_ALL:  m = 8'hff;
      default:  m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sub_bytes_ced_monitor_if.sv
// Byte-lane stream bus into and out of the CED monitor (valid/ready both ways).
interface sub_bytes_ced_monitor_if #(parameter int LANES = 4);
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]   out_err;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_err);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_err);
endinterface

// File: rtl/sbox_ced_lane.sv
// One byte lane: predictor on the stage-1 input side, S-box + fault + checker on the stage-2 side.
module sbox_ced_lane
  import sbox_ced_pkg::*;
(
  input  logic [7:0]       pred_in,
  output logic [SIG_W-1:0] pred_sig,
  input  logic [7:0]       data_in,
  input  logic [7:0]       fault,
  input  logic [SIG_W-1:0] sig_in,
  output logic [7:0]       data_out,
  output logic             err
);
  logic [7:0] sb;

  sub_bytes u_sb (.x(data_in), .y(sb));

  sub_bytes_quadratic_predictor u_pred (.x(pred_in), .sig(pred_sig));

  assign data_out = sb ^ fault;

  sub_bytes_quadratic_checker u_chk (.y(data_out), .sig(sig_in), .err(err));
endmodule

// File: rtl/sub_bytes.sv
// Single-byte AES SubBytes.
module sub_bytes
  import sbox_ced_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);
  assign y = sbox(x);
endmodule

// File: rtl/sub_bytes_quadratic_checker.sv
// Flags an S-box output whose signature disagrees with the prediction.
module sub_bytes_quadratic_checker
  import sbox_ced_pkg::*;
(
  input  logic [7:0]       y,
  input  logic [SIG_W-1:0] sig,
  output logic             err
);
  assign err = (quad_sig(y) != sig);
endmodule

// File: rtl/sub_bytes_quadratic_predictor.sv
// Predicts the quadratic signature of S(x) from the S-box input.
module sub_bytes_quadratic_predictor
  import sbox_ced_pkg::*;
(
  input  logic [7:0]       x,
  output logic [SIG_W-1:0] sig
);
  assign sig = quad_sig(sbox(x));
endmodule

// File: rtl/sub_bytes_ced_monitor.sv
// Multi-lane CED wrapper: 2-stage valid/ready pipeline, per-beat fault injection,
// sticky alarm and saturating beat/error/masked-fault counters.
module sub_bytes_ced_monitor
  import sbox_ced_pkg::*;
#(
  parameter  int LANES = 4,
  parameter  int CNT_W = 16,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sub_bytes_ced_monitor_if.slave bus,
  input  logic [1:0]             inj_mode,
  input  logic [LW-1:0]          inj_lane,
  input  logic [2:0]             inj_bit,
  input  logic                   clr,
  output logic                   alarm,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       mask_cnt
);
  logic                     rdy_en;
  logic                     s1_valid;
  logic [8*LANES-1:0]       s1_data;
  logic [SIG_W*LANES-1:0]   s1_sig;
  logic [SIG_W*LANES-1:0]   pred_sig;
  logic [1:0]               s1_mode;
  logic [LW-1:0]            s1_lane;
  logic [2:0]               s1_bit;
  logic [8*LANES-1:0]       lane_out;
  logic [LANES-1:0]         lane_err;
  logic [LANES-1:0]         tgt;
  logic [LANES-1:0]         s2_tgt;
  logic                     s2_adv;
  logic                     s1_adv;
  logic                     in_hs;
  logic                     out_hs;

  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  // rdy_en keeps in_ready low through reset and for the first edge after release.
  assign bus.in_ready = s1_adv && rdy_en;
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign out_hs       = bus.out_valid && bus.out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] fault;
    assign fault  = fault_mask(s1_mode, 32'(s1_lane), s1_bit, i);
    assign tgt[i] = |fault;

    sbox_ced_lane u_lane (
      .pred_in  (bus.in_data[8*i +: 8]),
      .pred_sig (pred_sig[SIG_W*i +: SIG_W]),
      .data_in  (s1_data[8*i +: 8]),
      .fault    (fault),
      .sig_in   (s1_sig[SIG_W*i +: SIG_W]),
      .data_out (lane_out[8*i +: 8]),
      .err      (lane_err[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sig   <= '0;
      s1_mode  <= '0;
      s1_lane  <= '0;
      s1_bit   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (s1_adv) begin
        s1_valid <= in_hs;
        if (in_hs) begin
          s1_data <= bus.in_data;
          s1_sig  <= pred_sig;
          s1_mode <= inj_mode;
          s1_lane <= inj_lane;
          s1_bit  <= inj_bit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_err   <= '0;
      s2_tgt        <= '0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= lane_out;
        bus.out_err  <= lane_err;
        s2_tgt       <= tgt;
      end
    end
  end

  // A beat is "masked" when something was injected yet no injected lane tripped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm    <= 1'b0;
      beat_cnt <= '0;
      err_cnt  <= '0;
      mask_cnt <= '0;
    end else if (clr) begin
      alarm    <= 1'b0;
      beat_cnt <= '0;
      err_cnt  <= '0;
      mask_cnt <= '0;
    end else if (out_hs) begin
      if (|bus.out_err) alarm <= 1'b1;
      if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
      if ((|bus.out_err) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      if ((|s2_tgt) && !(|(bus.out_err & s2_tgt)) && (mask_cnt != '1))
        mask_cnt <= mask_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sub_bytes_ced_monitor.sv
// Randomized bench for sub_bytes_ced_monitor against a table-driven S-box and signature model.
module tb_sub_bytes_ced_monitor;
  localparam int L = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sub_bytes_ced_monitor_if #(.LANES(L)) bus ();
  sub_bytes_ced_monitor_if #(.LANES(L)) bus4 ();

  logic [1:0]  inj_mode;
  logic [1:0]  inj_lane;
  logic [2:0]  inj_bit;
  logic        clr;
  logic        alarm, alarm4;
  logic [15:0] beat_cnt, err_cnt, mask_cnt;
  logic [3:0]  beat4, err4, mask4;

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.out_ready = bus.out_ready;

  sub_bytes_ced_monitor #(.LANES(L), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .inj_mode(inj_mode), .inj_lane(inj_lane), .inj_bit(inj_bit), .clr(clr),
    .alarm(alarm), .beat_cnt(beat_cnt), .err_cnt(err_cnt), .mask_cnt(mask_cnt)
  );

  sub_bytes_ced_monitor #(.LANES(L), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .inj_mode(inj_mode), .inj_lane(inj_lane), .inj_bit(inj_bit), .clr(clr),
    .alarm(alarm4), .beat_cnt(beat4), .err_cnt(err4), .mask_cnt(mask4)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] d;
    logic [3:0]  e;
    logic [3:0]  t;
    logic [1:0]  md;
    int          stamp;
    bit          lat;
  } exp_t;

  logic [7:0] sbm [256];
  exp_t       q[$];
  exp_t       e;
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  bit lat_on   = 1'b1;
  int rdy_mode = 0;
  int m_beat = 0, m_err = 0, m_mask = 0, m4_beat = 0, m4_err = 0, m4_mask = 0;
  bit m_alarm = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic int gm(input int a0, input int b0);
    int r = 0, a = a0, b = b0;
    while (b != 0) begin
      if ((b & 1) != 0) r ^= a;
      a = a << 1;
      if ((a & 256) != 0) a ^= 'h11b;
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [3:0] sigm(input logic [7:0] y);
    logic [7:0] mk [4];
    logic [3:0] r;
    mk = '{8'h55, 8'h33, 8'h0f, 8'hff};
    for (int k = 0; k < 4; k++)
      r[k] = (($countones(y & mk[k]) % 2) != 0) ^ (y[2*k] & y[2*k+1]);
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [1:0] md,
                                 input logic [1:0] ln, input logic [2:0] bt);
    exp_t r;
    logic [7:0] s, m;
    r.x = x; r.md = md; r.d = '0; r.e = '0; r.t = '0; r.stamp = 0; r.lat = 1'b0;
    for (int l = 0; l < L; l++) begin
      s = sbm[x[8*l +: 8]];
      m = 8'h00;
      if (md == 2'd3) m = 8'hff;
      else if (md == 2'd1 && int'(ln) == l) m = 8'hff;
      else if (md == 2'd2 && int'(ln) == l) m = 8'h01 << bt;
      r.d[8*l +: 8] = s ^ m;
      r.e[l] = (sigm(s ^ m) != sigm(s));
      r.t[l] = (m != 8'h00);
    end
    return r;
  endfunction

  initial begin
    int inv, s, b;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (x != 0 && gm(x, y) == 1) inv = y;
      s = 'h63;
      for (int i = 0; i < 8; i++) begin
        b = ((inv >> i) ^ (inv >> ((i+4)%8)) ^ (inv >> ((i+5)%8)) ^
             (inv >> ((i+6)%8)) ^ (inv >> ((i+7)%8))) & 1;
        s ^= b << i;
      end
      sbm[x] = 8'(s);
    end
  end

  // out_ready pattern 1,0,0,1 when rdy_mode is set
  initial begin
    int rc = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      bus.out_ready = (rdy_mode == 0) || (rc % 4 == 0) || (rc % 4 == 3);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && bus.out_valid) begin
        check("stall_data", bus.out_data, prev_data);
        check("stall_err", bus.out_err, prev_err);
      end
      if (q.size() >= 2 && bus.out_valid && !bus.out_ready)
        check("full_in_ready", bus.in_ready, 0);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_err   = bus.out_err;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("spurious_beat", 1, 0);
        else begin
          e = q.pop_front();
          check("out_data", bus.out_data, e.d);
          check("out_err", bus.out_err, e.e);
          check("err_untargeted", bus.out_err & ~e.t, 0);
          if (e.lat) check("latency", cyc - e.stamp, 2);
          for (int l = 0; l < L; l++) begin
            if (e.md == 2'd0 && e.x[8*l +: 8] == 8'h00) check("spot_00", bus.out_data[8*l +: 8], 8'h63);
            if (e.md == 2'd0 && e.x[8*l +: 8] == 8'h53) check("spot_53", bus.out_data[8*l +: 8], 8'hed);
          end
          if (m_beat < 65535) m_beat++;
          if (m4_beat < 15) m4_beat++;
          if (e.e != 0) begin
            m_alarm = 1'b1;
            if (m_err < 65535) m_err++;
            if (m4_err < 15) m4_err++;
          end
          if (e.t != 0 && (e.e & e.t) == 0) begin
            if (m_mask < 65535) m_mask++;
            if (m4_mask < 15) m4_mask++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.in_data, inj_mode, inj_lane, inj_bit);
        e.stamp = cyc;
        e.lat = lat_on;
        q.push_back(e);
      end
      if (clr) begin
        m_beat = 0; m_err = 0; m_mask = 0; m4_beat = 0; m4_err = 0; m4_mask = 0; m_alarm = 1'b0;
      end
    end
  end

  task automatic drive(input int n, input int kind, input bit rnd,
                       input logic [1:0] md, input logic [1:0] ln, input logic [2:0] bt);
    int i = 0, guard = 0;
    bit hs, fresh = 1'b1;
    while (i < n && guard < 4000) begin
      if (fresh) begin
        for (int l = 0; l < L; l++)
          bus.in_data[8*l +: 8] = (kind == 0) ? 8'(4*i + l) : 8'($urandom);
        inj_mode = rnd ? 2'($urandom_range(0, 3)) : md;
        inj_lane = rnd ? 2'($urandom_range(0, 3)) : ln;
        inj_bit  = rnd ? 3'($urandom_range(0, 7)) : bt;
      end
      bus.in_valid = 1'b1;
      @(negedge clk); hs = bus.in_ready;
      @(posedge clk); #1;
      fresh = hs;
      if (hs) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    inj_mode = 2'd0;
    if (i < n) check("drive_timeout", i, n);
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    check(tag, q.size(), 0);
  endtask

  task automatic check_cnts(input string ph);
    check({ph, "_beat_cnt"}, beat_cnt, m_beat);
    check({ph, "_err_cnt"}, err_cnt, m_err);
    check({ph, "_mask_cnt"}, mask_cnt, m_mask);
    check({ph, "_alarm"}, alarm, m_alarm);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0;
    inj_mode = 2'd0; inj_lane = 2'd0; inj_bit = 3'd0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_alarm", alarm, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 check("in_ready_at_release", bus.in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_release", bus.in_ready, 1);

    // no fault, sequential bytes 0x00..0xFF
    drive(64, 0, 1'b0, 2'd0, 2'd0, 3'd0);
    drain("p1_drain");
    check_cnts("p1");
    check("p1_beat64", beat_cnt, 64);
    check("p1_err0", err_cnt, 0);

    // whole-byte inversion on all lanes
    pulse_clr();
    drive(64, 0, 1'b0, 2'd3, 2'd0, 3'd0);
    drain("p2_drain");
    check_cnts("p2");
    check("p2_err_plus_mask", err_cnt + mask_cnt, 64);
    check("p2_alarm", alarm, 1);

    // single-bit flip, lane 1 bit 0
    pulse_clr();
    drive(64, 1, 1'b0, 2'd2, 2'd1, 3'd0);
    drain("p3_drain");
    check_cnts("p3");

    // backpressure with random injection
    pulse_clr();
    rdy_mode = 1; lat_on = 1'b0;
    drive(40, 1, 1'b1, 2'd0, 2'd0, 3'd0);
    drain("p4_drain");
    rdy_mode = 0; lat_on = 1'b1;
    @(posedge clk); #1;
    check_cnts("p4");
    check("p4_beat40", beat_cnt, 40);

    // saturation on the 4-bit instance, then clr racing a handshake
    pulse_clr();
    drive(20, 1, 1'b0, 2'd3, 2'd0, 3'd0);
    drain("p5_drain");
    check("sat_beat4", beat4, 15);
    check("sat_beat4_model", beat4, m4_beat);
    check("sat_err4", err4, m4_err);
    check("sat_mask4", mask4, m4_mask);
    check_cnts("p5");
    bus.in_valid = 1'b1; inj_mode = 2'd3; bus.in_data = $urandom;
    @(posedge clk); #1; bus.in_data = $urandom;
    @(posedge clk); #1; bus.in_data = $urandom; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0; bus.in_valid = 1'b0; inj_mode = 2'd0;
    check("clr_beat4", beat4, 0);
    check("clr_alarm4", alarm4, 0);
    check("clr_beat_cnt", beat_cnt, 0);
    check("clr_alarm", alarm, 0);
    drain("p5b_drain");
    check_cnts("p5b");

    // asynchronous reset with two beats in flight
    bus.in_valid = 1'b1; bus.in_data = $urandom;
    @(posedge clk); #1; bus.in_data = $urandom;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    check("pre_rst_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_beat_cnt", beat_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_alarm", alarm, 0);
    q.delete();
    m_beat = 0; m_err = 0; m_mask = 0; m4_beat = 0; m4_err = 0; m4_mask = 0; m_alarm = 1'b0;
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(3, 1, 1'b0, 2'd1, 2'd2, 3'd0);
    drain("p6_drain");
    check_cnts("p6");
    check("p6_beat3", beat_cnt, 3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
